// File: rtl/cpu_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited memory
// reads and buffers returned words with their addresses in a prefetch queue.
module cpu_fetch_queue #(
  parameter int unsigned     AW       = 16,
  parameter int unsigned     DW       = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [AW-1:0]                o_pc_addr,
  output logic                         o_pc_rd,
  input  logic                         i_pc_waitreq,
  input  logic [DW-1:0]                i_pc_rddata,
  input  logic                         i_redirect,
  input  logic [AW-1:0]                i_redirect_pc,
  output logic                         o_valid,
  output logic [DW-1:0]                o_instr,
  output logic [AW-1:0]                o_instr_pc,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] tag_pc_q, tag_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] instr_q [DEPTH];
  logic [DW-1:0] instr_d [DEPTH];
  logic [AW-1:0] ipc_q   [DEPTH];
  logic [AW-1:0] ipc_d   [DEPTH];

  logic [CW:0]   credit_used;
  logic          pc_rd;
  logic          accept;
  logic          push;
  logic          pop;

  // Credit counts the in-flight word so every return is guaranteed a free slot.
  // Gating with reset keeps the request low while the block is held in reset.
  always_comb begin
    credit_used = {1'b0, count_q} + (CW+1)'(inflight_q);
    pc_rd       = reset && !i_redirect && (credit_used < DEPTH_L);
    accept      = pc_rd && !i_pc_waitreq;
    push        = inflight_q && !i_redirect;
    pop         = (count_q != '0) && i_ready && !i_redirect;
  end

  always_comb begin
    pc_d       = pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = accept;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;

    if (accept) begin
      pc_d     = pc_q + AW'(PC_STEP);
      tag_pc_d = pc_q;
    end

    if (i_redirect) begin
      pc_d     = i_redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = i_pc_rddata;
        ipc_d[wr_ptr_q]   = tag_pc_q;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
    end
  end

  assign o_pc_addr  = pc_q;
  assign o_pc_rd    = pc_rd;
  assign o_valid    = (count_q != '0);
  assign o_instr    = instr_q[rd_ptr_q];
  assign o_instr_pc = ipc_q[rd_ptr_q];
  assign o_count    = count_q;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed bench for cpu_fetch_queue: a queue-level reference model checked every
// cycle, plus literal expectations at the key timing points.
module tb_cpu_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] o_pc_addr;
  logic        o_pc_rd;
  logic        i_pc_waitreq;
  logic [15:0] i_pc_rddata;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        o_valid;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;
  logic        i_ready;
  logic [2:0]  o_count;

  always #5 clk = ~clk;

  cpu_fetch_queue #(
    .AW(16), .DW(16), .DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_STEP(2)
  ) dut (
    .clk(clk), .reset(reset),
    .o_pc_addr(o_pc_addr), .o_pc_rd(o_pc_rd),
    .i_pc_waitreq(i_pc_waitreq), .i_pc_rddata(i_pc_rddata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .i_ready(i_ready), .o_count(o_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue entries are {instr, pc}
  logic [31:0] q[$];
  logic [15:0] m_pc;
  logic [15:0] m_tag;
  bit          m_infl;

  // Memory responder state
  bit          mem_pending;
  logic [15:0] mem_addr;
  int          n_acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc        = 16'h0000;
    m_tag       = 16'h0000;
    m_infl      = 1'b0;
    mem_pending = 1'b0;
  endtask

  // Entered at a negedge: drive inputs, compare, advance model, wait next negedge.
  task automatic cycle(input bit rdy, input bit wr, input bit redir, input logic [15:0] rpc);
    bit exp_rd;
    bit m_acc;
    bit dut_acc;
    i_ready       = rdy;
    i_pc_waitreq  = wr;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_pc_rddata   = mem_pending ? (mem_addr ^ 16'hA5A5) : 16'hDEAD;
    #1;
    exp_rd = !redir && ((q.size() + (m_infl ? 1 : 0)) < DEPTH);
    chk("pc_rd",    32'(o_pc_rd),   32'(exp_rd));
    chk("pc_addr",  32'(o_pc_addr), 32'(m_pc));
    chk("valid",    32'(o_valid),   32'(q.size() != 0));
    chk("count",    32'(o_count),   32'(q.size()));
    if (q.size() != 0) begin
      chk("instr",    32'(o_instr),    32'(q[0][31:16]));
      chk("instr_pc", 32'(o_instr_pc), 32'(q[0][15:0]));
    end
    dut_acc = o_pc_rd && !wr;
    if (dut_acc) n_acc++;
    mem_pending = dut_acc;
    mem_addr    = o_pc_addr;

    m_acc = exp_rd && !wr;
    if (redir) begin
      q.delete();
      m_pc   = rpc;
      m_infl = 1'b0;
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (m_infl) q.push_back({m_tag ^ 16'hA5A5, m_tag});
      if (m_acc) begin
        m_tag = m_pc;
        m_pc  = m_pc + 16'd2;
      end
      m_infl = m_acc;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse inside one low clock phase; outputs checked while held.
  task automatic do_reset();
    i_pc_waitreq = 1'b1;
    i_redirect   = 1'b0;
    i_ready      = 1'b0;
    i_pc_rddata  = mem_pending ? (mem_addr ^ 16'hA5A5) : 16'hDEAD;
    #2 reset = 1'b0;
    #1;
    chk("rst_pc_rd",    32'(o_pc_rd),    32'd0);
    chk("rst_valid",    32'(o_valid),    32'd0);
    chk("rst_instr",    32'(o_instr),    32'd0);
    chk("rst_instr_pc", 32'(o_instr_pc), 32'd0);
    chk("rst_count",    32'(o_count),    32'd0);
    chk("rst_pc_addr",  32'(o_pc_addr),  32'd0);
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b0;
    i_pc_waitreq  = 1'b0;
    i_pc_rddata   = 16'h0000;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
    i_ready       = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Cold start, streaming
    cycle(1, 0, 0, 16'h0);
    cycle(1, 0, 0, 16'h0);
    chk("cold_valid",    32'(o_valid),    32'd1);
    chk("cold_head_pc",  32'(o_instr_pc), 32'h0000);
    chk("cold_head_ins", 32'(o_instr),    32'hA5A5);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 16'h0);
    chk("stream_pc",  32'(o_instr_pc), 32'h000C);
    chk("stream_ins", 32'(o_instr),    32'hA5A9);

    // Back-pressure: fill then drain
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 16'h0);
    chk("full_reqs",    32'(n_acc),     32'd4);
    chk("full_count",   32'(o_count),   32'd4);
    chk("full_pc_rd",   32'(o_pc_rd),   32'd0);
    chk("full_pc_addr", 32'(o_pc_addr), 32'h0008);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 32'(o_instr_pc), 32'(2 * i));
      cycle(1, 0, 0, 16'h0);
    end
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 16'h0);

    // Memory stall on address 4
    do_reset();
    cycle(1, 0, 0, 16'h0);
    cycle(1, 0, 0, 16'h0);
    chk("stall_addr0", 32'(o_pc_addr), 32'h0004);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 16'h0);
    chk("stall_addr1", 32'(o_pc_addr), 32'h0004);
    chk("stall_rd",    32'(o_pc_rd),   32'd1);
    cycle(1, 0, 0, 16'h0);
    cycle(1, 0, 0, 16'h0);
    chk("stall_head_v",  32'(o_valid),    32'd1);
    chk("stall_head_pc", 32'(o_instr_pc), 32'h0004);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 16'h0);

    // Redirect while full with a response in flight
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 16'h0);
    chk("pre_redir_count", 32'(o_count), 32'd3);
    cycle(1, 0, 1, 16'h0100);
    chk("redir_count", 32'(o_count),   32'd0);
    chk("redir_addr",  32'(o_pc_addr), 32'h0100);
    cycle(1, 0, 0, 16'h0);
    cycle(1, 0, 0, 16'h0);
    chk("redir_valid", 32'(o_valid),    32'd1);
    chk("redir_pc",    32'(o_instr_pc), 32'h0100);
    chk("redir_ins",   32'(o_instr),    32'hA4A5);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 16'h0);

    // Back-to-back redirects: newer PC wins
    cycle(1, 0, 1, 16'h0300);
    cycle(1, 0, 1, 16'h0200);
    chk("redir2_addr", 32'(o_pc_addr), 32'h0200);
    cycle(1, 0, 0, 16'h0);
    cycle(1, 0, 0, 16'h0);
    chk("redir2_pc", 32'(o_instr_pc), 32'h0200);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h0);

    // PC wrap
    cycle(1, 0, 1, 16'hFFFC);
    cycle(1, 0, 0, 16'h0);
    cycle(1, 0, 0, 16'h0);
    chk("wrap_pc0", 32'(o_instr_pc), 32'hFFFC);
    cycle(1, 0, 0, 16'h0);
    chk("wrap_pc1", 32'(o_instr_pc), 32'hFFFE);
    cycle(1, 0, 0, 16'h0);
    chk("wrap_pc2", 32'(o_instr_pc), 32'h0000);
    chk("wrap_ins2", 32'(o_instr),   32'hA5A5);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h0);

    // Reset mid-stream with a response pending, then cold restart
    do_reset();
    cycle(1, 0, 0, 16'h0);
    cycle(1, 0, 0, 16'h0);
    chk("restart_pc", 32'(o_instr_pc), 32'h0000);
    chk("restart_v",  32'(o_valid),    32'd1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
